// File: rtl/fifo_wr_arbiter_if.sv
// fifo_wr_arbiter_if: requester handshake and FIFO write-port bundle for the write arbiter
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8
);
  logic [NUM_REQ-1:0]            i_req_valid;
  logic [NUM_REQ-1:0]            i_req_last;
  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data;
  logic [NUM_REQ-1:0]            o_req_ready;
  logic                          i_w_full;
  logic                          o_w_inc;
  logic [DATA_WIDTH-1:0]         o_w_data;
  logic [NUM_REQ-1:0]            o_grant;
  logic                          o_busy;
  logic                          o_trunc;
  modport master (
    output i_req_valid, i_req_last, i_req_data, i_w_full,
    input  o_req_ready, o_w_inc, o_w_data, o_grant, o_busy, o_trunc
  );
  modport slave (
    input  i_req_valid, i_req_last, i_req_data, i_w_full,
    output o_req_ready, o_w_inc, o_w_data, o_grant, o_busy, o_trunc
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter sharing the FIFO write port among requesters
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 16
) (
  input logic              i_w_clk,
  input logic              i_rst_n,
  fifo_wr_arbiter_if.slave bus
);
  localparam int PW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(MAX_BURST + 1);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [PW-1:0]      own_q, own_d, rr_ptr_q, rr_ptr_d, sel;
  logic [CW-1:0]      beat_cnt_q, beat_cnt_d;
  logic               trunc_q, trunc_d;
  logic               busy, xfer, last, cap;
  assign busy            = state_q == BUSY;
  assign xfer            = busy & bus.i_req_valid[own_q] & ~bus.i_w_full;
  assign last            = bus.i_req_last[own_q];
  assign cap             = beat_cnt_q == CW'(MAX_BURST - 1);
  assign bus.o_req_ready = busy & ~bus.i_w_full ? grant_q : '0;
  assign bus.o_w_inc     = xfer;
  assign bus.o_w_data    = busy ? bus.i_req_data[int'(own_q)*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign bus.o_grant     = grant_q;
  assign bus.o_busy      = busy;
  assign bus.o_trunc     = trunc_q;
  // first valid requester at or after rr_ptr; descending scan leaves the nearest one
  always_comb begin
    sel = rr_ptr_q;
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (bus.i_req_valid[(int'(rr_ptr_q) + i) % NUM_REQ]) sel = PW'((int'(rr_ptr_q) + i) % NUM_REQ);
  end
  // arbitration in IDLE, beat counting and burst release in BUSY
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    own_d      = own_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    trunc_d    = 1'b0;
    if (!busy) begin
      if (|bus.i_req_valid) begin
        state_d = BUSY;
        grant_d = NUM_REQ'(1) << sel;
        own_d   = sel;
      end
    end else if (xfer) begin
      beat_cnt_d = beat_cnt_q + 1'b1;
      if (last | cap) begin
        state_d    = IDLE;
        grant_d    = '0;
        rr_ptr_d   = own_q == PW'(NUM_REQ - 1) ? '0 : own_q + 1'b1;
        beat_cnt_d = '0;
        trunc_d    = ~last;
      end
    end
  end
  // state registers, cleared asynchronously so a reset abandons any burst
  always_ff @(posedge i_w_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      own_q      <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
      trunc_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      own_q      <= own_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
      trunc_q    <= trunc_d;
    end
  end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed self-checking bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   wr_cnt = 0;
  int   viol = 0;
  fifo_wr_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(8)) bus ();
  fifo_wr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .MAX_BURST(16)) dut (
    .i_w_clk(clk),
    .i_rst_n(rst_n),
    .bus(bus)
  );
  always #5 clk = ~clk;
  // write counter and full-flag invariant monitor
  always @(posedge clk) begin
    if (bus.o_w_inc) wr_cnt++;
    if (bus.o_w_inc && bus.i_w_full) viol++;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #2;
  endtask
  task automatic settle();
    #1;
  endtask
  task automatic set_data(input int k, input logic [7:0] d);
    bus.i_req_data[k*8 +: 8] = d;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    bus.i_req_valid = '0;
    bus.i_req_last = '0;
    bus.i_req_data = '0;
    bus.i_w_full = 1'b0;
    #3;
    rst_n = 1'b1;
    wr_cnt = 0;
  endtask
  initial begin
    bus.i_req_valid = '0;
    bus.i_req_last = '0;
    bus.i_req_data = '0;
    bus.i_w_full = 1'b0;
    #12;
    chk("rst_grant", bus.o_grant, 0);
    chk("rst_busy", bus.o_busy, 0);
    chk("rst_trunc", bus.o_trunc, 0);
    chk("rst_ready", bus.o_req_ready, 0);
    chk("rst_inc", bus.o_w_inc, 0);
    chk("rst_wdata", bus.o_w_data, 0);
    step();
    do_reset();
    // test 1: req1 three-beat burst
    bus.i_req_valid = 4'b0010;
    set_data(1, 8'h11);
    step();
    settle();
    chk("t1_grant", bus.o_grant, 4'b0010);
    chk("t1_busy", bus.o_busy, 1);
    chk("t1_inc0", bus.o_w_inc, 1);
    chk("t1_data0", bus.o_w_data, 8'h11);
    step();
    set_data(1, 8'h12);
    settle();
    chk("t1_inc1", bus.o_w_inc, 1);
    chk("t1_data1", bus.o_w_data, 8'h12);
    step();
    set_data(1, 8'h13);
    bus.i_req_last = 4'b0010;
    settle();
    chk("t1_inc2", bus.o_w_inc, 1);
    chk("t1_data2", bus.o_w_data, 8'h13);
    step();
    bus.i_req_valid = '0;
    bus.i_req_last = '0;
    settle();
    chk("t1_idle_grant", bus.o_grant, 0);
    chk("t1_idle_inc", bus.o_w_inc, 0);
    chk("t1_idle_wdata", bus.o_w_data, 0);
    chk("t1_writes", wr_cnt, 3);
    bus.i_req_valid = 4'b0110;
    bus.i_req_last = 4'b0110;
    step();
    chk("t1_rrptr2", bus.o_grant, 4'b0100);
    // test 2: all requesters, single-beat bursts
    do_reset();
    bus.i_req_valid = 4'b1111;
    bus.i_req_last = 4'b1111;
    for (int k = 0; k < 4; k++) set_data(k, 8'(8'hA0 + k));
    for (int n = 0; n < 5; n++) begin
      step();
      chk($sformatf("t2_grant%0d", n), bus.o_grant, 32'(1) << (n % 4));
      chk($sformatf("t2_inc%0d", n), bus.o_w_inc, 1);
      chk($sformatf("t2_data%0d", n), bus.o_w_data, 32'(8'hA0 + (n % 4)));
      step();
      chk($sformatf("t2_gap_grant%0d", n), bus.o_grant, 0);
      chk($sformatf("t2_gap_inc%0d", n), bus.o_w_inc, 0);
    end
    chk("t2_writes", wr_cnt, 5);
    // test 3: req2 four-beat burst stalled by full
    do_reset();
    bus.i_req_valid = 4'b0100;
    set_data(2, 8'h21);
    step();
    chk("t3_grant", bus.o_grant, 4'b0100);
    chk("t3_inc1", bus.o_w_inc, 1);
    step();
    set_data(2, 8'h22);
    settle();
    chk("t3_data2", bus.o_w_data, 8'h22);
    step();
    set_data(2, 8'h23);
    bus.i_w_full = 1'b1;
    for (int n = 0; n < 3; n++) begin
      settle();
      chk($sformatf("t3_stall_inc%0d", n), bus.o_w_inc, 0);
      chk($sformatf("t3_stall_rdy%0d", n), bus.o_req_ready, 0);
      chk($sformatf("t3_stall_grant%0d", n), bus.o_grant, 4'b0100);
      step();
    end
    bus.i_w_full = 1'b0;
    settle();
    chk("t3_inc3", bus.o_w_inc, 1);
    chk("t3_data3", bus.o_w_data, 8'h23);
    chk("t3_rdy3", bus.o_req_ready, 4'b0100);
    step();
    set_data(2, 8'h24);
    bus.i_req_last = 4'b0100;
    settle();
    chk("t3_inc4", bus.o_w_inc, 1);
    step();
    bus.i_req_valid = '0;
    bus.i_req_last = '0;
    settle();
    chk("t3_release", bus.o_grant, 0);
    chk("t3_writes", wr_cnt, 4);
    // test 4: req0 hits the beat cap, req3 waiting
    do_reset();
    bus.i_req_valid = 4'b1001;
    bus.i_req_last = 4'b1000;
    set_data(3, 8'h33);
    step();
    chk("t4_grant0", bus.o_grant, 4'b0001);
    for (int n = 0; n < 16; n++) begin
      set_data(0, 8'(n));
      settle();
      chk($sformatf("t4_data%0d", n), bus.o_w_data, n);
      chk($sformatf("t4_trunc_lo%0d", n), bus.o_trunc, 0);
      step();
    end
    chk("t4_writes", wr_cnt, 16);
    chk("t4_trunc", bus.o_trunc, 1);
    chk("t4_idle", bus.o_grant, 0);
    step();
    chk("t4_trunc_off", bus.o_trunc, 0);
    chk("t4_grant3", bus.o_grant, 4'b1000);
    chk("t4_data3", bus.o_w_data, 8'h33);
    step();
    chk("t4_rel3", bus.o_grant, 0);
    step();
    chk("t4_regrant0", bus.o_grant, 4'b0001);
    // test 5: asynchronous reset mid-burst
    do_reset();
    bus.i_req_valid = 4'b0010;
    set_data(1, 8'h51);
    step();
    step();
    set_data(1, 8'h52);
    step();
    bus.i_req_valid = 4'b1011;
    set_data(1, 8'h53);
    settle();
    chk("t5_pre_grant", bus.o_grant, 4'b0010);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_grant", bus.o_grant, 0);
    chk("t5_rst_inc", bus.o_w_inc, 0);
    chk("t5_rst_busy", bus.o_busy, 0);
    #1;
    rst_n = 1'b1;
    step();
    chk("t5_grant_lowest", bus.o_grant, 4'b0001);
    // test 6: owner drops valid while another requester waits
    do_reset();
    bus.i_req_valid = 4'b1000;
    set_data(3, 8'h61);
    step();
    chk("t6_grant", bus.o_grant, 4'b1000);
    chk("t6_inc1", bus.o_w_inc, 1);
    step();
    bus.i_req_valid = 4'b0001;
    wr_cnt = 0;
    for (int n = 0; n < 4; n++) begin
      settle();
      chk($sformatf("t6_hold%0d", n), bus.o_grant, 4'b1000);
      chk($sformatf("t6_noinc%0d", n), bus.o_w_inc, 0);
      chk($sformatf("t6_rdy0_%0d", n), 32'(bus.o_req_ready[0]), 0);
      step();
    end
    chk("t6_nowrites", wr_cnt, 0);
    bus.i_req_valid = 4'b1001;
    bus.i_req_last = 4'b1000;
    set_data(3, 8'h62);
    settle();
    chk("t6_inc_last", bus.o_w_inc, 1);
    chk("t6_data_last", bus.o_w_data, 8'h62);
    chk("t6_rdy0_last", 32'(bus.o_req_ready[0]), 0);
    step();
    chk("t6_release", bus.o_grant, 0);
    step();
    chk("t6_grant0", bus.o_grant, 4'b0001);
    chk("inv_full", viol, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
